// File: rtl/eq_mix_engine_if.sv
// Frame-level bus between the FIR bank outputs, the band/volume mixer and the codec output registers.
// master drives band samples, pots and clr_flags; slave (the mixer) returns mixed samples and status.
interface eq_mix_engine_if #(
  parameter int NUM_CH    = 2,
  parameter int NUM_BANDS = 5,
  parameter int SMPL_W    = 16,
  parameter int POT_W     = 12
);
  logic                                band_vld;
  logic [NUM_CH*NUM_BANDS*SMPL_W-1:0]  band_smpl;
  logic [NUM_BANDS*POT_W-1:0]          band_pot;
  logic [POT_W-1:0]                    vol_pot;
  logic                                clr_flags;
  logic [NUM_CH*SMPL_W-1:0]            mix_out;
  logic                                out_vld;
  logic                                busy;
  logic                                sat_flag;
  logic                                ovr_flag;

  modport master (
    output band_vld, band_smpl, band_pot, vol_pot, clr_flags,
    input  mix_out, out_vld, busy, sat_flag, ovr_flag
  );

  modport slave (
    input  band_vld, band_smpl, band_pot, vol_pot, clr_flags,
    output mix_out, out_vld, busy, sat_flag, ovr_flag
  );
endinterface

// File: rtl/eq_mix_engine.sv
// Time-multiplexed band-scale / saturating-sum / volume mixer sharing one multiplier across all channels.
// out_vld follows NUM_CH*(NUM_BANDS+1)+1 edges after capture; band_vld while the FSM is not idle is dropped and flagged.
module eq_mix_engine #(
  parameter int NUM_CH    = 2,
  parameter int NUM_BANDS = 5,
  parameter int SMPL_W    = 16,
  parameter int POT_W     = 12
) (
  input  logic            clk,
  input  logic            rst,
  eq_mix_engine_if.slave  bus
);

  localparam int SCL_W  = SMPL_W + 2;
  localparam int PROD_W = SMPL_W + POT_W + 1;
  localparam int ACC_W  = SCL_W + $clog2(NUM_BANDS);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int B_W    = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int SMPL_BUS_W = NUM_CH * NUM_BANDS * SMPL_W;
  localparam int POT_BUS_W  = NUM_BANDS * POT_W;
  localparam int MIX_W      = NUM_CH * SMPL_W;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-SMPL_W+1){1'b0}}, {(SMPL_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-SMPL_W+1){1'b1}}, {(SMPL_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BAND, VOL, DONE} state_t;

  function automatic logic clipped(input logic signed [ACC_W-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic signed [SMPL_W-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[SMPL_W-1:0];
    if (v < SAT_MIN) return SAT_MIN[SMPL_W-1:0];
    return v[SMPL_W-1:0];
  endfunction

  state_t                    state_q, state_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [B_W-1:0]            b_q, b_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [SMPL_BUS_W-1:0]     smpl_q, smpl_d;
  logic [POT_BUS_W-1:0]      pot_q, pot_d;
  logic [POT_W-1:0]          vol_q, vol_d;
  logic [MIX_W-1:0]          mix_q, mix_d;
  logic                      out_vld_q, out_vld_d;
  logic                      sat_flag_q, sat_flag_d;
  logic                      ovr_flag_q, ovr_flag_d;

  logic signed [SMPL_W-1:0]  band_x;
  logic [POT_W-1:0]          band_p;
  logic signed [SMPL_W-1:0]  mul_x;
  logic [POT_W-1:0]          mul_p;
  logic signed [PROD_W-1:0]  prod;
  logic signed [SCL_W-1:0]   scaled;
  logic signed [ACC_W-1:0]   vol_ext;
  logic signed [SMPL_W-1:0]  vol_sat;
  logic                      sat_set;
  logic                      ovr_set;

  // Operand select for the current (channel, band) slot from the captured frame.
  always_comb begin
    band_x = '0;
    band_p = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        if (ch_q == CH_W'(c) && b_q == B_W'(b)) begin
          band_x = smpl_q[(c*NUM_BANDS+b)*SMPL_W +: SMPL_W];
        end
      end
    end
    for (int b = 0; b < NUM_BANDS; b++) begin
      if (b_q == B_W'(b)) band_p = pot_q[b*POT_W +: POT_W];
    end
  end

  // Pot is zero-extended so codes above mid-scale stay positive gains.
  assign prod    = PROD_W'(mul_x) * PROD_W'($signed({1'b0, mul_p}));
  assign scaled  = prod[PROD_W-1:POT_W-1];
  assign vol_ext = ACC_W'(scaled);
  assign vol_sat = sat(vol_ext);

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    b_d       = b_q;
    acc_d     = acc_q;
    smpl_d    = smpl_q;
    pot_d     = pot_q;
    vol_d     = vol_q;
    mix_d     = mix_q;
    out_vld_d = 1'b0;
    sat_set   = 1'b0;
    mul_x     = band_x;
    mul_p     = band_p;
    ovr_set   = bus.band_vld && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (bus.band_vld) begin
          smpl_d  = bus.band_smpl;
          pot_d   = bus.band_pot;
          vol_d   = bus.vol_pot;
          ch_d    = '0;
          b_d     = '0;
          acc_d   = '0;
          state_d = BAND;
        end
      end
      BAND: begin
        acc_d = acc_q + ACC_W'(scaled);
        if (b_q == B_W'(NUM_BANDS-1)) state_d = VOL;
        else                          b_d     = b_q + B_W'(1);
      end
      VOL: begin
        mul_x   = sat(acc_q);
        mul_p   = vol_q;
        sat_set = clipped(acc_q) || clipped(vol_ext);
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_q == CH_W'(c)) mix_d[c*SMPL_W +: SMPL_W] = vol_sat;
        end
        if (ch_q == CH_W'(NUM_CH-1)) begin
          state_d = DONE;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          b_d     = '0;
          acc_d   = '0;
          state_d = BAND;
        end
      end
      DONE: begin
        out_vld_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    sat_flag_d = bus.clr_flags ? 1'b0 : (sat_flag_q || sat_set);
    ovr_flag_d = bus.clr_flags ? 1'b0 : (ovr_flag_q || ovr_set);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      smpl_q     <= '0;
      pot_q      <= '0;
      vol_q      <= '0;
      mix_q      <= '0;
      out_vld_q  <= 1'b0;
      sat_flag_q <= 1'b0;
      ovr_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      smpl_q     <= smpl_d;
      pot_q      <= pot_d;
      vol_q      <= vol_d;
      mix_q      <= mix_d;
      out_vld_q  <= out_vld_d;
      sat_flag_q <= sat_flag_d;
      ovr_flag_q <= ovr_flag_d;
    end
  end

  assign bus.mix_out  = mix_q;
  assign bus.out_vld  = out_vld_q;
  assign bus.busy     = (state_q != IDLE) || out_vld_q;
  assign bus.sat_flag = sat_flag_q;
  assign bus.ovr_flag = ovr_flag_q;

endmodule

// File: tb/tb_eq_mix_engine.sv
// Scoreboard bench for eq_mix_engine: frames are modelled when launched, results compared on out_vld.
module tb_eq_mix_engine;
  localparam int NC = 2;
  localparam int NB = 5;
  localparam int SW = 16;
  localparam int PW = 12;
  localparam int LAT = NC * (NB + 1) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  eq_mix_engine_if #(.NUM_CH(NC), .NUM_BANDS(NB), .SMPL_W(SW), .POT_W(PW)) bus ();

  eq_mix_engine #(.NUM_CH(NC), .NUM_BANDS(NB), .SMPL_W(SW), .POT_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  logic signed [SW-1:0] smpl [NC][NB];
  logic [PW-1:0]        pot  [NB];
  logic [PW-1:0]        vol;
  logic [NC*SW-1:0]     exp_q [$];
  bit                   exp_sat = 1'b0;

  task automatic drive_inputs();
    for (int c = 0; c < NC; c++)
      for (int b = 0; b < NB; b++)
        bus.band_smpl[(c*NB+b)*SW +: SW] = smpl[c][b];
    for (int b = 0; b < NB; b++) bus.band_pot[b*PW +: PW] = pot[b];
    bus.vol_pot = vol;
  endtask

  task automatic set_all(input logic signed [SW-1:0] s, input logic [PW-1:0] p, input logic [PW-1:0] v);
    for (int c = 0; c < NC; c++)
      for (int b = 0; b < NB; b++) smpl[c][b] = s;
    for (int b = 0; b < NB; b++) pot[b] = p;
    vol = v;
  endtask

  // Reference model in plain integer arithmetic; pushes the expected mix_out word.
  task automatic push_expected();
    logic [NC*SW-1:0] m;
    longint acc, v;
    m = '0;
    for (int c = 0; c < NC; c++) begin
      acc = 0;
      for (int b = 0; b < NB; b++)
        acc += (longint'(smpl[c][b]) * longint'({1'b0, pot[b]})) >>> (PW - 1);
      if (acc > 32767) begin acc = 32767; exp_sat = 1'b1; end
      else if (acc < -32768) begin acc = -32768; exp_sat = 1'b1; end
      v = (acc * longint'({1'b0, vol})) >>> (PW - 1);
      if (v > 32767) begin v = 32767; exp_sat = 1'b1; end
      else if (v < -32768) begin v = -32768; exp_sat = 1'b1; end
      m[c*SW +: SW] = SW'(v);
    end
    exp_q.push_back(m);
  endtask

  // Called one delta after a posedge; returns one delta after the capture edge.
  task automatic start_frame();
    drive_inputs();
    bus.band_vld = 1'b1;
    @(posedge clk); #1;
    bus.band_vld = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (bus.out_vld) lat = n;
    end
  endtask

  task automatic pop_expected(output logic [NC*SW-1:0] e);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 'x;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    tests++;
    if (bus.mix_out !== '0 || bus.out_vld !== 1'b0 || bus.busy !== 1'b0 ||
        bus.sat_flag !== 1'b0 || bus.ovr_flag !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: mix=%h vld=%b busy=%b sat=%b ovr=%b, want all zero",
               bus.mix_out, bus.out_vld, bus.busy, bus.sat_flag, bus.ovr_flag);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_unity();
    int lat;
    logic [NC*SW-1:0] e;
    set_all(0, 12'h800, 12'h800);
    smpl[0][0] = 16'sd1000;
    smpl[1][4] = -16'sd1234;
    push_expected();
    start_frame();
    tests++;
    if (bus.busy !== 1'b1) begin fails++; $display("FAIL unity_busy: got %b want 1", bus.busy); end
    wait_out(lat);
    pop_expected(e);
    tests++;
    if (lat !== LAT) begin fails++; $display("FAIL unity_latency: got %0d want %0d", lat, LAT); end
    tests++;
    if (bus.mix_out !== e) begin fails++; $display("FAIL unity_model: got %h want %h", bus.mix_out, e); end
    tests++;
    if ($signed(bus.mix_out[SW-1:0]) !== 16'sd1000 || $signed(bus.mix_out[2*SW-1:SW]) !== -16'sd1234) begin
      fails++;
      $display("FAIL unity_const: got ch0=%0d ch1=%0d want 1000 -1234",
               $signed(bus.mix_out[SW-1:0]), $signed(bus.mix_out[2*SW-1:SW]));
    end
    tests++;
    if (bus.sat_flag !== 1'b0) begin fails++; $display("FAIL unity_sat: got %b want 0", bus.sat_flag); end
    @(posedge clk); #1;
    tests++;
    if (bus.out_vld !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL unity_release: vld=%b busy=%b want 0 0", bus.out_vld, bus.busy);
    end
  endtask

  task automatic test_gain_floor();
    int lat;
    logic [NC*SW-1:0] e;
    set_all(0, 12'h800, 12'h800);
    smpl[0][1] = 16'sd3;
    pot[1] = 12'hC00;
    push_expected();
    start_frame();
    wait_out(lat);
    pop_expected(e);
    tests++;
    if (bus.mix_out !== e || $signed(bus.mix_out[SW-1:0]) !== 16'sd4) begin
      fails++;
      $display("FAIL gain_ch0: got %h (ch0=%0d) want %h (ch0=4)", bus.mix_out, $signed(bus.mix_out[SW-1:0]), e);
    end
    set_all(0, 12'h7FF, 12'h800);
    for (int b = 0; b < NB; b++) smpl[1][b] = -16'sd1;
    push_expected();
    start_frame();
    wait_out(lat);
    pop_expected(e);
    tests++;
    if (bus.mix_out !== e || $signed(bus.mix_out[2*SW-1:SW]) !== -16'sd5) begin
      fails++;
      $display("FAIL floor_ch1: got %h (ch1=%0d) want %h (ch1=-5)", bus.mix_out, $signed(bus.mix_out[2*SW-1:SW]), e);
    end
  endtask

  task automatic test_saturation();
    int lat;
    logic [NC*SW-1:0] e;
    set_all(16'sd30000, 12'hFFF, 12'h800);
    push_expected();
    start_frame();
    wait_out(lat);
    pop_expected(e);
    tests++;
    if (bus.mix_out !== e || bus.mix_out !== {16'h7FFF, 16'h7FFF}) begin
      fails++;
      $display("FAIL sat_pos: got %h want %h", bus.mix_out, {16'h7FFF, 16'h7FFF});
    end
    tests++;
    if (bus.sat_flag !== 1'b1) begin fails++; $display("FAIL sat_pos_flag: got %b want 1", bus.sat_flag); end
    set_all(-16'sd30000, 12'hFFF, 12'h800);
    push_expected();
    start_frame();
    wait_out(lat);
    pop_expected(e);
    tests++;
    if (bus.mix_out !== e || bus.mix_out !== {16'h8000, 16'h8000}) begin
      fails++;
      $display("FAIL sat_neg: got %h want %h", bus.mix_out, {16'h8000, 16'h8000});
    end
  endtask

  task automatic test_volume();
    int lat;
    logic [NC*SW-1:0] e;
    set_all(0, 12'h800, 12'h000);
    smpl[0][0] = 16'sd1000;
    smpl[1][4] = -16'sd1234;
    push_expected();
    start_frame();
    wait_out(lat);
    pop_expected(e);
    tests++;
    if (bus.mix_out !== e || bus.mix_out !== '0) begin
      fails++;
      $display("FAIL volume_zero: got %h want %h", bus.mix_out, e);
    end
    tests++;
    if (bus.sat_flag !== exp_sat) begin
      fails++;
      $display("FAIL volume_sticky_sat: got %b want %b", bus.sat_flag, exp_sat);
    end
  endtask

  task automatic test_clear_flags();
    int lat;
    logic [NC*SW-1:0] e;
    bus.clr_flags = 1'b1;
    @(posedge clk); #1;
    bus.clr_flags = 1'b0;
    exp_sat = 1'b0;
    tests++;
    if (bus.sat_flag !== 1'b0) begin fails++; $display("FAIL clr_pulse: sat=%b want 0", bus.sat_flag); end
    // Clear held through a clipping frame must win over the set.
    set_all(16'sd30000, 12'hFFF, 12'h800);
    push_expected();
    bus.clr_flags = 1'b1;
    start_frame();
    wait_out(lat);
    bus.clr_flags = 1'b0;
    pop_expected(e);
    exp_sat = 1'b0;
    tests++;
    if (bus.mix_out !== e) begin fails++; $display("FAIL clr_frame_data: got %h want %h", bus.mix_out, e); end
    tests++;
    if (bus.sat_flag !== 1'b0) begin fails++; $display("FAIL clr_priority: sat=%b want 0", bus.sat_flag); end
  endtask

  task automatic test_overrun();
    int lat, extra;
    logic [NC*SW-1:0] e;
    lat = -1;
    extra = 0;
    set_all(0, 12'h800, 12'h800);
    smpl[0][0] = 16'sd1000;
    smpl[1][4] = -16'sd1234;
    push_expected();
    start_frame();
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (n == 4) begin
        set_all(16'sd5000, 12'hFFF, 12'hFFF);
        drive_inputs();
        bus.band_vld = 1'b1;
      end
      if (n == 5) bus.band_vld = 1'b0;
      if (n == LAT + 1) begin
        tests++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL ovr_busy_end: got %b want 0", bus.busy); end
      end
      if (bus.out_vld) begin
        if (lat < 0) begin
          lat = n;
          pop_expected(e);
          tests++;
          if (bus.mix_out !== e) begin fails++; $display("FAIL ovr_hold_data: got %h want %h", bus.mix_out, e); end
        end else extra++;
      end
    end
    tests++;
    if (lat !== LAT) begin fails++; $display("FAIL ovr_latency: got %0d want %0d", lat, LAT); end
    tests++;
    if (extra !== 0) begin fails++; $display("FAIL ovr_extra_vld: got %0d extra pulses want 0", extra); end
    tests++;
    if (bus.ovr_flag !== 1'b1) begin fails++; $display("FAIL ovr_flag: got %b want 1", bus.ovr_flag); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [NC*SW-1:0] e;
    bus.clr_flags = 1'b1;
    @(posedge clk); #1;
    bus.clr_flags = 1'b0;
    set_all(0, 12'h800, 12'h800);
    smpl[0][1] = 16'sd3;
    pot[1] = 12'hC00;
    push_expected();
    start_frame();
    wait_out(lat);
    pop_expected(e);
    tests++;
    if (bus.mix_out !== e) begin fails++; $display("FAIL b2b_first: got %h want %h", bus.mix_out, e); end
    // Launch during the out_vld cycle: capture lands exactly LAT+1 edges after the previous one.
    set_all(16'sd777, 12'hA00, 12'h900);
    smpl[1][2] = -16'sd20000;
    push_expected();
    start_frame();
    wait_out(lat);
    pop_expected(e);
    tests++;
    if (lat !== LAT) begin fails++; $display("FAIL b2b_latency: got %0d want %0d", lat, LAT); end
    tests++;
    if (bus.mix_out !== e) begin fails++; $display("FAIL b2b_second: got %h want %h", bus.mix_out, e); end
    tests++;
    if (bus.ovr_flag !== 1'b0) begin fails++; $display("FAIL b2b_no_ovr: got %b want 0", bus.ovr_flag); end
  endtask

  task automatic test_reset_mid_frame();
    int lat, seen;
    logic [NC*SW-1:0] e;
    seen = 0;
    set_all(16'sd30000, 12'hFFF, 12'h800);
    start_frame();
    for (int n = 1; n <= 7; n++) begin
      @(posedge clk); #1;
      if (n == 3) bus.band_vld = 1'b1;
      if (n == 4) bus.band_vld = 1'b0;
    end
    tests++;
    if (bus.ovr_flag !== 1'b1 || bus.sat_flag !== 1'b1 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL midrst_pre: ovr=%b sat=%b busy=%b want 1 1 1", bus.ovr_flag, bus.sat_flag, bus.busy);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (bus.mix_out !== '0 || bus.out_vld !== 1'b0 || bus.busy !== 1'b0 ||
        bus.sat_flag !== 1'b0 || bus.ovr_flag !== 1'b0) begin
      fails++;
      $display("FAIL midrst_clear: mix=%h vld=%b busy=%b sat=%b ovr=%b want all zero",
               bus.mix_out, bus.out_vld, bus.busy, bus.sat_flag, bus.ovr_flag);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    exp_sat = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bus.out_vld) seen++;
    end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL midrst_no_vld: got %0d pulses want 0", seen); end
    set_all(16'sd100, 12'h800, 12'h800);
    smpl[1][0] = -16'sd321;
    push_expected();
    start_frame();
    wait_out(lat);
    pop_expected(e);
    tests++;
    if (lat !== LAT || bus.mix_out !== e) begin
      fails++;
      $display("FAIL midrst_recover: lat=%0d mix=%h want lat=%0d mix=%h", lat, bus.mix_out, LAT, e);
    end
    tests++;
    if (exp_q.size() !== 0) begin fails++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t reached without finishing, want finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.band_vld  = 1'b0;
    bus.clr_flags = 1'b0;
    set_all(0, 12'h800, 12'h800);
    drive_inputs();
    test_reset();
    test_unity();
    test_gain_floor();
    test_saturation();
    test_volume();
    test_clear_flags();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/eq_mix_engine.md
Name: eq_mix_engine

Overview:
- Parametrised, time-multiplexed successor to the per-channel band-scale/sum/volume datapath of the equalizer core.
- One shared multiplier scales NUM_BANDS filter outputs per channel by their band pots, sums them with saturation, then applies the volume pot.
- Handles NUM_CH channels per sample frame.
- Sits between the FIR bank outputs and the codec output registers; band_vld is pulsed once per audio frame.

Parameters:
- NUM_CH, 2, audio channels per frame.
- NUM_BANDS, 5, bands summed per channel.
- SMPL_W, 16, signed sample width.
- POT_W, 12, unsigned pot width; mid-code 2^(POT_W-1) is unity gain.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- band_vld  input  1  one-cycle pulse; band_smpl and pots are valid this cycle.
- band_smpl  input  NUM_CH*NUM_BANDS*SMPL_W  signed band samples; channel c, band b at slice index c*NUM_BANDS+b.
- band_pot  input  NUM_BANDS*POT_W  unsigned band gains; band b at slice b.
- vol_pot  input  POT_W  unsigned volume gain.
- mix_out  output  NUM_CH*SMPL_W  signed mixed samples; channel c at slice c.
- out_vld  output  1  one-cycle pulse when all of mix_out has been updated.
- busy  output  1  high from the capture edge until out_vld deasserts.
- sat_flag  output  1  sticky: any sum or volume result was clipped.
- ovr_flag  output  1  sticky: band_vld arrived while busy.
- clr_flags  input  1  synchronous clear of sat_flag and ovr_flag.

Behaviour:
- Reset (async, rst=1): mix_out=0, out_vld=0, busy=0, sat_flag=0, ovr_flag=0, FSM=IDLE, counters=0. A reset mid-frame aborts the frame with no out_vld and outputs zeroed.
- FSM states:
  - IDLE: on band_vld, latch band_smpl, band_pot and vol_pot into internal registers; go to BAND with ch=0, b=0, acc=0.
  - BAND: acc += scale(smpl[ch][b], pot[b]) on each edge. At b=NUM_BANDS-1 go to VOL; otherwise b++.
  - VOL: mix_out[ch] <= sat(scale(sat(acc), vol_pot)). If ch=NUM_CH-1 go to DONE; else ch++, b=0, acc=0, go to BAND.
  - DONE: out_vld=1 for this one cycle; go to IDLE.
- Latency: out_vld is high in the cycle that follows NUM_CH*(NUM_BANDS+1)+1 edges after the capture edge. With the defaults, that is edge 13 after capture.
- mix_out channels update one at a time during VOL cycles and hold otherwise. Consumers sample mix_out only while out_vld is high.
- Input stability:
  - Inputs are used only at the capture edge; later changes to band_smpl or pots do not affect the frame in flight.
  - band_vld while not IDLE (including in DONE) is ignored and sets ovr_flag. The frame in flight completes unchanged.
- scale(x, p):
  - Compute (signed x * zero-extended p) as a SMPL_W+POT_W+1-bit product.
  - Arithmetic shift right by POT_W-1 (floor, no rounding). Result is SMPL_W+2 bits.
  - Examples: p=2^(POT_W-1) gives x exactly; p=0 gives 0; x=-1 with p=0x7FF gives -1.
- acc width is SMPL_W+2+clog2(NUM_BANDS). Individual band terms are never clipped; acc cannot overflow.
- sat(): clamps to [-2^(SMPL_W-1), 2^(SMPL_W-1)-1]. sat is applied to acc before volume scaling and again to the volume result. Any clamp sets sat_flag in the same edge.
- Flags: clr_flags has priority over a same-cycle set. Flags are otherwise sticky until reset.
- Frame rate: back-to-back band_vld pulses are legal. Minimum pulse spacing is NUM_CH*(NUM_BANDS+1)+2 cycles; closer pulses are dropped per the ovr_flag rule.

Test Plan:
- Unity path: all pots 0x800; ch0 band0=1000, ch1 band4=-1234, other bands 0. Pulse band_vld. Expect out_vld exactly 13 cycles after capture; mix_out ch0=1000, ch1=-1234; sat_flag=0.
- Gain and floor: ch0 band1=3, B1 pot=0xC00, vol 0x800 gives 4 (4.5 floored). ch1 all bands -1, pots 0x7FF, vol 0x800 gives -5.
- Saturation: every band=30000, all band pots 0xFFF, vol 0x800. Each term is 59985, sum 299925. Expect mix_out=32767 on both channels and sat_flag=1. Repeat with -30000: expect -32768. Then pulse clr_flags: expect sat_flag=0.
- Volume: same inputs as unity test with vol_pot=0. Expect both outputs 0; sat_flag unchanged.
- Overrun and input hold: second band_vld 5 cycles after the first, with changed samples and pots. Expect first-frame results unchanged, ovr_flag=1, only one out_vld. A pulse 14 cycles after the first is accepted.
- Reset mid-frame: assert rst during cycle 7 of a frame. Expect outputs, flags and busy immediately 0 and no out_vld. A new frame after release produces correct results.
